// File: rtl/load_store_unit.sv
// Memory-access/writeback stage: one load/store at a time over a req/ack
// data-memory bus, with lane steering, load extension and error pulses.
module load_store_unit #(
    parameter int TIMEOUT     = 16,
    parameter bit SUPPRESS_R0 = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rt,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_regWrite,
    output logic [4:0]  wb_writeAdd,
    output logic [31:0] wb_writeData,
    output logic        misalign,
    output logic        illegal,
    output logic        bus_err
);
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

    state_t state, state_nx;

    logic [5:0]    op_q;
    logic [4:0]    rt_q;
    logic [1:0]    lane_q;
    logic [CW-1:0] cnt;

    logic          legal;
    logic          is_store;
    logic          mis;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [31:0]   shifted;
    logic [31:0]   ext;

    // Request decode: lane enables, store replication and alignment check
    always_comb begin
        legal     = 1'b1;
        mis       = 1'b0;
        be        = 4'b0000;
        wdata_rep = req_wdata;
        is_store  = req_opcode[3];
        unique case (req_opcode)
            OP_LB, OP_LBU, OP_SB: begin
                be        = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                mis       = req_addr[0];
                be        = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            OP_LW, OP_SW: begin
                mis = |req_addr[1:0];
                be  = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
    end

    // Selected lane lands in the low bits; lw always has lane 0
    always_comb begin
        shifted = mem_rdata >> {lane_q, 3'b000};
        unique case (op_q)
            OP_LB:   ext = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  ext = {24'h0, shifted[7:0]};
            OP_LH:   ext = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        req_ready   = 1'b0;
        mem_req     = 1'b0;
        wb_regWrite = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && legal && !mis) state_nx = ACCESS;
            end
            ACCESS: begin
                mem_req = 1'b1;
                if (mem_ack)          state_nx = mem_we ? IDLE : WB;
                else if (cnt == LAST) state_nx = IDLE;
            end
            WB: begin
                wb_regWrite = !(SUPPRESS_R0 && rt_q == 5'd0);
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= '0;
            rt_q         <= '0;
            lane_q       <= '0;
            cnt          <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            wb_writeAdd  <= '0;
            wb_writeData <= '0;
            misalign     <= 1'b0;
            illegal      <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign <= 1'b0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!legal) begin
                            illegal <= 1'b1;
                        end else if (mis) begin
                            misalign <= 1'b1;
                        end else begin
                            op_q      <= req_opcode;
                            rt_q      <= req_rt;
                            lane_q    <= req_addr[1:0];
                            cnt       <= '0;
                            mem_we    <= is_store;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= be;
                            mem_wdata <= wdata_rep;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            wb_writeData <= ext;
                            wb_writeAdd  <= rt_q;
                        end
                    end else if (cnt == LAST) begin
                        bus_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, randomized requests against
// an arithmetic reference model, and reset/ack corner sequences.
module tb_load_store_unit;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [31:0] RD    = 32'h80FF7F11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_opcode = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rt = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_regWrite;
    logic [4:0]  wb_writeAdd;
    logic [31:0] wb_writeData;
    logic        misalign;
    logic        illegal;
    logic        bus_err;

    load_store_unit #(.TIMEOUT(16), .SUPPRESS_R0(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rt(req_rt),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_regWrite(wb_regWrite), .wb_writeAdd(wb_writeAdd),
        .wb_writeData(wb_writeData),
        .misalign(misalign), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [4:0]  rt;
        logic [31:0] rd;
        int          ack;
        int          nreq;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic        we;
        int          nwb;
        logic [31:0] wbd;
        logic [2:0]  pulse;
        int          ready;
    } vec_t;

    int total = 0;
    int bad = 0;
    int cur = 0;

    int          r_nreq, r_nwb, r_npulse, r_ready, r_unstable;
    logic [2:0]  r_pulse;
    logic [31:0] r_addr, r_mwd, r_wbd;
    logic [3:0]  r_be;
    logic        r_we;
    logic [4:0]  r_wadd;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h expected=%h", name, cur, act, exp);
        end
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t   e;
        int     size;
        int     lane;
        bit     load;
        bit     sgn;
        longint m;
        longint val;
        e = v;
        e.nreq = 0; e.be = '0; e.mwd = '0; e.we = 1'b0;
        e.nwb = 0; e.wbd = '0; e.pulse = 3'b000; e.ready = 1;
        lane = int'(v.addr % 4);
        load = v.op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        sgn  = v.op inside {OP_LB, OP_LH};
        if (v.op inside {OP_LB, OP_LBU, OP_SB})      size = 1;
        else if (v.op inside {OP_LH, OP_LHU, OP_SH}) size = 2;
        else if (v.op inside {OP_LW, OP_SW})         size = 4;
        else                                         size = 0;
        if (size == 0) begin
            e.pulse = 3'b010;
        end else if (lane % size != 0) begin
            e.pulse = 3'b100;
        end else begin
            m = (longint'(1) << (8 * size)) - 1;
            e.be = 4'(((1 << size) - 1) << lane);
            e.we = !load;
            e.mwd = 32'((longint'(v.wd) & m) *
                    (size == 1 ? 64'h01010101 : size == 2 ? 64'h00010001 : 64'h1));
            if (v.ack >= 1 && v.ack <= 16) begin
                e.nreq = v.ack;
                if (load) begin
                    val = (longint'(v.rd) >> (8 * lane)) & m;
                    if (sgn && val > m / 2) val = val - (m + 1);
                    e.wbd = 32'(val);
                    e.nwb = (v.rt != 0) ? 1 : 0;
                    e.ready = v.ack + 2;
                end else begin
                    e.ready = v.ack + 1;
                end
            end else begin
                e.nreq = 16;
                e.pulse = 3'b001;
                e.ready = 17;
            end
        end
        return e;
    endfunction

    // Issue one request at a negedge and follow it until req_ready returns
    task automatic run(input vec_t v);
        bit first;
        first = 1'b1;
        r_nreq = 0; r_nwb = 0; r_npulse = 0; r_ready = 0; r_unstable = 0;
        r_pulse = '0;
        req_valid = 1'b1; req_opcode = v.op; req_addr = v.addr;
        req_wdata = v.wd; req_rt = v.rt;
        @(negedge clk);
        req_valid = 1'b0;
        req_opcode = 6'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_rt = 5'($urandom);
        for (int c = 1; c <= 60; c++) begin
            if (mem_req) begin
                r_nreq++;
                if (first) begin
                    r_addr = mem_addr; r_be = mem_be;
                    r_mwd = mem_wdata; r_we = mem_we;
                    first = 1'b0;
                end else if ({mem_addr, mem_be, mem_wdata, mem_we} !==
                             {r_addr, r_be, r_mwd, r_we}) begin
                    r_unstable++;
                end
            end
            if (wb_regWrite) begin
                r_nwb++; r_wadd = wb_writeAdd; r_wbd = wb_writeData;
            end
            if (misalign || illegal || bus_err) r_npulse++;
            r_pulse = r_pulse | {misalign, illegal, bus_err};
            if (req_ready) begin
                r_ready = c;
                break;
            end
            mem_ack = mem_req && (r_nreq == v.ack);
            mem_rdata = mem_ack ? v.rd : $urandom;
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic check_run(input vec_t e);
        chk("nreq", r_nreq, e.nreq);
        chk("ready_cycle", r_ready, e.ready);
        chk("pulse", 32'(r_pulse), 32'(e.pulse));
        chk("pulse_width", r_npulse, (e.pulse != 0) ? 1 : 0);
        chk("held_stable", r_unstable, 0);
        chk("nwb", r_nwb, e.nwb);
        if (e.nreq > 0) begin
            chk("mem_addr", r_addr, e.addr & 32'hFFFF_FFFC);
            chk("mem_be", 32'(r_be), 32'(e.be));
            chk("mem_we", 32'(r_we), 32'(e.we));
            if (e.we) chk("mem_wdata", r_mwd, e.mwd);
        end
        if (e.nwb > 0) begin
            chk("wb_writeAdd", 32'(r_wadd), 32'(e.rt));
            chk("wb_writeData", r_wbd, e.wbd);
        end
    endtask

    vec_t tbl[14];
    vec_t v;
    vec_t e;
    logic [5:0] ops[8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    int n;

    initial begin
        tbl[0]  = '{OP_LB,  32'h102, 32'h0, 5'd5, RD, 1, 1, 4'b0100, 32'h0, 1'b0, 1, 32'hFFFFFFFF, 3'b000, 3};
        tbl[1]  = '{OP_LBU, 32'h102, 32'h0, 5'd5, RD, 1, 1, 4'b0100, 32'h0, 1'b0, 1, 32'h000000FF, 3'b000, 3};
        tbl[2]  = '{OP_LH,  32'h102, 32'h0, 5'd6, RD, 1, 1, 4'b1100, 32'h0, 1'b0, 1, 32'hFFFF80FF, 3'b000, 3};
        tbl[3]  = '{OP_LHU, 32'h102, 32'h0, 5'd6, RD, 1, 1, 4'b1100, 32'h0, 1'b0, 1, 32'h000080FF, 3'b000, 3};
        tbl[4]  = '{OP_LW,  32'h100, 32'h0, 5'd9, RD, 1, 1, 4'b1111, 32'h0, 1'b0, 1, 32'h80FF7F11, 3'b000, 3};
        tbl[5]  = '{OP_SB,  32'h103, 32'hAB, 5'd0, RD, 1, 1, 4'b1000, 32'hABABABAB, 1'b1, 0, 32'h0, 3'b000, 2};
        tbl[6]  = '{OP_SH,  32'h102, 32'h1234, 5'd0, RD, 1, 1, 4'b1100, 32'h12341234, 1'b1, 0, 32'h0, 3'b000, 2};
        tbl[7]  = '{OP_LW,  32'h102, 32'h0, 5'd4, RD, 1, 0, 4'b0000, 32'h0, 1'b0, 0, 32'h0, 3'b100, 1};
        tbl[8]  = '{6'b000000, 32'h100, 32'h0, 5'd4, RD, 1, 0, 4'b0000, 32'h0, 1'b0, 0, 32'h0, 3'b010, 1};
        tbl[9]  = '{OP_LW,  32'h200, 32'h0, 5'd7, RD, 0, 16, 4'b1111, 32'h0, 1'b0, 0, 32'h0, 3'b001, 17};
        tbl[10] = '{OP_LW,  32'h200, 32'h0, 5'd7, RD, 16, 16, 4'b1111, 32'h0, 1'b0, 1, 32'h80FF7F11, 3'b000, 18};
        tbl[11] = '{OP_LW,  32'h300, 32'h0, 5'd0, RD, 1, 1, 4'b1111, 32'h0, 1'b0, 0, 32'h0, 3'b000, 3};
        tbl[12] = '{OP_SW,  32'h10, 32'hDEADBEEF, 5'd0, RD, 3, 3, 4'b1111, 32'hDEADBEEF, 1'b1, 0, 32'h0, 3'b000, 4};
        tbl[13] = '{OP_LB,  32'h101, 32'h0, 5'd31, RD, 2, 2, 4'b0010, 32'h0, 1'b0, 1, 32'h0000007F, 3'b000, 4};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_ctrl", 32'({mem_req, mem_we, wb_regWrite, misalign, illegal, bus_err}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_wb_add", 32'(wb_writeAdd), 32'd0);
        chk("rst_wb_data", wb_writeData, 32'd0);

        for (int i = 0; i < 14; i++) begin
            cur = i;
            run(tbl[i]);
            check_run(tbl[i]);
        end

        // Ack while idle must not start anything
        cur = 100;
        n = 0;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_req || wb_regWrite || !req_ready) n++;
        end
        mem_ack = 1'b0;
        chk("idle_ack_ignored", n, 0);

        // Reset in the middle of an access drops it without a clock edge
        cur = 101;
        req_valid = 1'b1; req_opcode = OP_LW; req_addr = 32'h40; req_rt = 5'd3;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        chk("async_rst_ready", 32'(req_ready), 32'd1);
        chk("async_rst_mem_be", 32'(mem_be), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_req || wb_regWrite) n++;
        end
        chk("no_wb_after_rst", n, 0);

        for (int i = 0; i < 60; i++) begin
            int sel;
            cur = 200 + i;
            v.op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            v.addr = $urandom;
            sel = $urandom_range(0, 2);
            if (sel == 1) v.addr[1:0] = 2'b00;
            if (sel == 2) v.addr[0] = 1'b0;
            v.wd = $urandom;
            v.rt = 5'($urandom);
            v.rd = $urandom;
            sel = $urandom_range(0, 19);
            v.ack = (sel == 0) ? 0 : (sel == 1) ? 16 : (sel == 2) ? 17 : $urandom_range(1, 4);
            e = model(v);
            run(v);
            check_run(e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access and writeback stage that sits between execute and the register file. It drives the register file's write port (regWrite/writeAdd/writeData), the producer side of the interface the register file consumes.
Accepts one load/store request at a time over a valid/ready handshake and runs a req/ack transaction to data memory. Performs byte-lane alignment, store lane replication and load sign/zero extension, then issues a single-cycle register writeback for loads.
Detects misaligned accesses, illegal opcodes and memory timeouts.

Parameters:
TIMEOUT, 16, cycles mem_req may stay high without mem_ack before abort (must be ≥1)
SUPPRESS_R0, 1, when 1 loads targeting register 0 perform the memory read but do not assert wb_regWrite

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  execute stage presents a request
req_ready  output  1  unit can accept (high only in IDLE)
req_opcode  input  6  MIPS opcode
req_addr  input  32  effective byte address
req_wdata  input  32  store data (rt value), low bits significant for sb/sh
req_rt  input  5  load destination register
mem_req  output  1  memory transaction active
mem_we  output  1  1 = store
mem_addr  output  32  word address (req_addr with [1:0] = 0)
mem_be  output  4  byte enables, bit k = bits 8k+7:8k
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  memory completes transaction this cycle
mem_rdata  input  32  read data, valid when mem_ack=1
wb_regWrite  output  1  register write strobe, one cycle
wb_writeAdd  output  5  destination register
wb_writeData  output  32  extended load value
misalign  output  1  one-cycle pulse: misaligned request rejected
illegal  output  1  one-cycle pulse: opcode not load/store
bus_err  output  1  one-cycle pulse: timeout abort

Behaviour:
- Opcodes: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011. All other opcodes are illegal.
- Little-endian: byte lane = addr[1:0]; halfword lane = addr[1].
- FSM states:
  - IDLE: req_ready=1. Transfer on req_valid && req_ready at a clock edge. On transfer, all request fields are registered; later changes on req_* are ignored.
  - Illegal opcode: illegal=1 next cycle, stay IDLE.
  - Misaligned request (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]≠0): misalign=1 next cycle, stay IDLE, no mem_req.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_req=1; mem_we/mem_addr/mem_be/mem_wdata held stable until the transaction ends.
  - A cycle counter starts at 0. mem_ack is sampled each edge.
  - Ack on a store → IDLE. Ack on a load → register mem_rdata, go to WB.
  - If the counter reaches TIMEOUT-1 with no ack → bus_err=1 next cycle, mem_req=0, IDLE, no writeback.
- WB: wb_regWrite=1 for exactly one cycle (0 if SUPPRESS_R0=1 and rt=0); wb_writeAdd=rt. Then IDLE.
- Minimum load latency: accept at edge 0; mem_req high in cycle 1; ack in cycle 1 → WB in cycle 2 → req_ready=1 in cycle 3.
- Minimum store latency: req_ready=1 again in cycle 2.
- mem_be: byte = 1<<addr[1:0]; half = 0011 or 1100; word = 1111.
- mem_wdata: byte replicated ×4; half replicated ×2; word as-is.
- Extension: lb/lh sign-extend the selected lane; lbu/lhu zero-extend; lw passes the word through.
- wb_writeData and wb_writeAdd hold their last values outside WB. Sinks qualify them only by wb_regWrite.
- mem_ack outside ACCESS is ignored. An ack in the same edge as the timeout completes normally; no bus_err.
- Reset (async, any state): state=IDLE; mem_req, mem_we, wb_regWrite, misalign, illegal, bus_err = 0; mem_addr, mem_be, mem_wdata, wb_writeAdd, wb_writeData = 0; counter=0. An in-flight transaction is dropped with no writeback. req_ready reads 1 after rst_n rises.

Test Plan:
- lb @0x00000102, mem_rdata=0x80FF7F11, rt=5, ack in first ACCESS cycle → mem_addr=0x100, mem_be=0100, wb_regWrite pulse, wb_writeAdd=5, wb_writeData=0xFFFFFFFF. Same stimulus with lbu → 0x000000FF.
- lh / lhu @0x102, same mem_rdata → 0xFFFF80FF / 0x000080FF. lw @0x100 → 0x80FF7F11.
- sb @0x103, req_wdata=0x000000AB → mem_we=1, mem_be=1000, mem_wdata=0xABABABAB, no wb_regWrite. sh @0x102, req_wdata=0x00001234 → mem_be=1100, mem_wdata=0x12341234.
- lw @0x102 → misalign pulse one cycle, mem_req never rises. Opcode 000000 → illegal pulse. Back-to-back: req_ready=1 in the following cycle for both.
- Load with mem_ack held low, TIMEOUT=16 → mem_req high exactly 16 cycles, bus_err pulse, no wb_regWrite. Ack on cycle 16 → normal completion, no bus_err.
- rst_n low mid-ACCESS → mem_req drops without waiting for clk, no writeback. Load to rt=0 with SUPPRESS_R0=1 → memory read occurs, wb_regWrite stays 0.
